// File: rtl/vga_scanout_reader.sv
// Scan-out side of the 2x2-replicated 3-bit framebuffer: 640x480@60 timing, pixel fetch, DAC drive.
// Defining VGA_SCANOUT_TESTPATTERN_EN adds a test_mode input that shows eight vertical colour bars.
module vga_scanout_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17
) (
  input  logic              clock,
  input  logic              reset,
`ifdef VGA_SCANOUT_TESTPATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [2:0]        mem_data,
  output logic              frame_start,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK,
  output logic              VGA_SYNC,
  output logic              VGA_CLK
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FB_WIDTH = H_ACTIVE >> SCALE_SHIFT;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic              phase_q, phase_d;
  logic              pix_en;
  logic [9:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic              visible, hs_now, vs_now, wrap;
  logic [9:0]        x, y;
  logic [ADDR_W-1:0] fb_addr;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d, fs_q, fs_d;
  logic              hs_a_q, hs_a_d, vs_a_q, vs_a_d, vis_a_q, vis_a_d;
  logic              hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [2:0]        rgb_q, rgb_d;
  logic [2:0]        pix_col;
  logic              rd_block;

  always_comb begin
    pix_en  = phase_q;
    visible = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_now  = ~((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_now  = ~((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    wrap    = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    x       = hcnt_q >> SCALE_SHIFT;
    y       = vcnt_q >> SCALE_SHIFT;
    // 320 = 256 + 64, so the standard mode needs only shifts and adds
    if (FB_WIDTH == 320)
      fb_addr = (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
    else
      fb_addr = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
  end

`ifdef VGA_SCANOUT_TESTPATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_now, bar_a_q;

  always_comb begin
    bar_now = '0;
    for (int i = 1; i < 8; i++)
      if (hcnt_q >= 10'(i * BAR_W)) bar_now = 3'(i);
  end

  always_ff @(posedge clock) begin
    if (reset)       bar_a_q <= '0;
    else if (pix_en) bar_a_q <= bar_now;
  end

  always_comb begin
    pix_col  = test_mode ? bar_a_q : mem_data;
    rd_block = test_mode;
  end
`else
  always_comb begin
    pix_col  = mem_data;
    rd_block = 1'b0;
  end
`endif

  always_comb begin
    phase_d = ~phase_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    fs_d    = 1'b0;
    hs_a_d  = hs_a_q;
    vs_a_d  = vs_a_q;
    vis_a_d = vis_a_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    rgb_d   = rgb_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      fs_d    = wrap;
      if (visible) addr_d = fb_addr;
      rd_d    = visible && !rd_block;
      hs_a_d  = hs_now;
      vs_a_d  = vs_now;
      vis_a_d = visible;
      // mem_data for the stage-A address has been stable for a full clock here
      hs_d    = hs_a_q;
      vs_d    = vs_a_q;
      blank_d = vis_a_q;
      rgb_d   = vis_a_q ? pix_col : 3'b000;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      fs_q    <= 1'b0;
      hs_a_q  <= 1'b1;
      vs_a_q  <= 1'b1;
      vis_a_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      phase_q <= phase_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      fs_q    <= fs_d;
      hs_a_q  <= hs_a_d;
      vs_a_q  <= vs_a_d;
      vis_a_q <= vis_a_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign frame_start = fs_q;
  assign VGA_R       = {8{rgb_q[2]}};
  assign VGA_G       = {8{rgb_q[1]}};
  assign VGA_B       = {8{rgb_q[0]}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK   = blank_q;
  assign VGA_SYNC    = 1'b0;
  assign VGA_CLK     = phase_q;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: a full-size instance plus a shrunken-timing instance so whole
// frames fit in a short run; both are checked every clock against a pixel-index model.
module tb_vga_scanout_reader;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } cfg_t;

  typedef struct {
    int          n;
    int          sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   tm  = 1'b0;

  always #10 clk = ~clk;

  logic [16:0] b_addr, s_addr;
  logic        b_rd, s_rd, b_fs, s_fs;
  logic [2:0]  b_data = '0, s_data = '0;
  logic [7:0]  b_r, b_g, b_b, s_r, s_g, s_b;
  logic        b_hs, b_vs, b_blank, b_sync, b_clk;
  logic        s_hs, s_vs, s_blank, s_sync, s_clk;

  logic [2:0] fb_big   [76800];
  logic [2:0] fb_small [32];

  vga_scanout_reader u_big (
    .clock(clk), .reset(rst),
`ifdef VGA_SCANOUT_TESTPATTERN_EN
    .test_mode(tm),
`endif
    .mem_addr(b_addr), .mem_rd(b_rd), .mem_data(b_data), .frame_start(b_fs),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK(b_blank), .VGA_SYNC(b_sync), .VGA_CLK(b_clk)
  );

  vga_scanout_reader #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clock(clk), .reset(rst),
`ifdef VGA_SCANOUT_TESTPATTERN_EN
    .test_mode(tm),
`endif
    .mem_addr(s_addr), .mem_rd(s_rd), .mem_data(s_data), .frame_start(s_fs),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK(s_blank), .VGA_SYNC(s_sync), .VGA_CLK(s_clk)
  );

  // synchronous RAMs, one clock of read latency
  always @(posedge clk) begin
    b_data <= fb_big[b_addr];
    s_data <= fb_small[s_addr];
  end

  int   n = 0;
  int   checks = 0;
  int   failures = 0;
  cfg_t CFG [2];
  int   last_addr [2];
  int   hs_fall = -1, vs_fall = -1, fs_last = -1;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d n=%0d actual=%0h required=%0h", nm, c, n, act, exp);
    end
  endtask

  function automatic int htot(int c);
    return CFG[c].ha + CFG[c].hf + CFG[c].hs + CFG[c].hb;
  endfunction

  function automatic int vtot(int c);
    return CFG[c].va + CFG[c].vf + CFG[c].vs + CFG[c].vb;
  endfunction

  function automatic void hv(int c, int k, output int h, output int v);
    h = k % htot(c);
    v = (k / htot(c)) % vtot(c);
  endfunction

  function automatic bit vis(int c, int h, int v);
    return (h < CFG[c].ha) && (v < CFG[c].va);
  endfunction

  function automatic int fbaddr(int c, int h, int v);
    return (v / 2) * (CFG[c].ha / 2) + (h / 2);
  endfunction

  function automatic logic [2:0] fbcol(int c, int a);
    return (c == 0) ? fb_big[a] : fb_small[a];
  endfunction

  function automatic logic [23:0] expand(logic [2:0] p);
    return {{8{p[2]}}, {8{p[1]}}, {8{p[0]}}};
  endfunction

  // outputs after the n-th clock since reset: stage A shows pixel (n-2)/2, stage B pixel (n-4)/2
  task automatic check_dut(int c, logic [16:0] addr, logic rd, logic fs, logic [7:0] r,
                           logic [7:0] g, logic [7:0] b, logic hs, logic vs, logic blank,
                           logic sync, logic vclk);
    int h, v, k, fr;
    logic [2:0] col;
    logic e_rd, e_fs, e_hs, e_vs, e_blank;
    e_rd = 1'b0;
    if (n >= 2) begin
      k = (n - 2) / 2;
      hv(c, k, h, v);
      e_rd = vis(c, h, v) && !tm;
    end
    fr   = htot(c) * vtot(c);
    e_fs = (n >= 2) && (n % 2 == 0) && (((n - 2) / 2) % fr == fr - 1);
    e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; col = 3'b000;
    if (n >= 4) begin
      k = (n - 4) / 2;
      hv(c, k, h, v);
      e_blank = vis(c, h, v);
      e_hs = !(h >= CFG[c].ha + CFG[c].hf && h < CFG[c].ha + CFG[c].hf + CFG[c].hs);
      e_vs = !(v >= CFG[c].va + CFG[c].vf && v < CFG[c].va + CFG[c].vf + CFG[c].vs);
      if (e_blank) col = tm ? 3'(h / (CFG[c].ha / 8)) : fbcol(c, fbaddr(c, h, v));
    end
    chk("vga_clk", c, 32'(vclk), 32'(n % 2));
    chk("vga_sync", c, 32'(sync), 32'd0);
    chk("mem_rd", c, 32'(rd), 32'(e_rd));
    chk("mem_addr", c, 32'(addr), 32'(last_addr[c]));
    chk("frame_start", c, 32'(fs), 32'(e_fs));
    chk("hs", c, 32'(hs), 32'(e_hs));
    chk("vs", c, 32'(vs), 32'(e_vs));
    chk("blank", c, 32'(blank), 32'(e_blank));
    chk("rgb", c, 32'({r, g, b}), 32'(expand(col)));
  endtask

  task automatic measure();
    if (n > 0) begin
      if (hs_prev && !b_hs) begin
        if (hs_fall >= 0) chk("hs_period", 0, n - hs_fall, 1600);
        hs_fall = n;
      end
      if (!hs_prev && b_hs && hs_fall >= 0) chk("hs_low", 0, n - hs_fall, 192);
      if (vs_prev && !s_vs) vs_fall = n;
      if (!vs_prev && s_vs && vs_fall >= 0) chk("vs_low", 1, n - vs_fall, 96);
      if (s_fs) begin
        chk("fs_period", 1, (fs_last < 0) ? n : n - fs_last, 576);
        fs_last = n;
      end
    end
    hs_prev = b_hs;
    vs_prev = s_vs;
  endtask

  task automatic step();
    int h, v;
    @(posedge clk);
    if (rst) begin
      n = 0;
      last_addr[0] = 0; last_addr[1] = 0;
      hs_fall = -1; vs_fall = -1; fs_last = -1;
    end else begin
      n++;
      if (n >= 2 && n % 2 == 0)
        for (int c = 0; c < 2; c++) begin
          hv(c, (n - 2) / 2, h, v);
          if (vis(c, h, v)) last_addr[c] = fbaddr(c, h, v);
        end
    end
    #1;
    check_dut(0, b_addr, b_rd, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_blank, b_sync, b_clk);
    check_dut(1, s_addr, s_rd, s_fs, s_r, s_g, s_b, s_hs, s_vs, s_blank, s_sync, s_clk);
    measure();
  endtask

  task automatic run_to(int target, string nm);
    int guard = 0;
    while (n < target && guard < 20000) begin
      step();
      guard++;
    end
    chk({nm, "_reached"}, 0, n, target);
  endtask

  vec_t tbl [$];

  task automatic add(int nn, int sel, logic [31:0] exp, string name);
    vec_t e;
    e.n = nn; e.sel = sel; e.exp = exp; e.name = name;
    tbl.push_back(e);
  endtask

  initial begin
    logic [31:0] act;
    int rs;
    CFG[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
    CFG[1] = '{16, 2, 4, 2, 8, 1, 2, 1};
    for (int i = 0; i < 76800; i++) fb_big[i] = 3'($urandom);
    for (int i = 0; i < 32; i++) fb_small[i] = 3'($urandom);
    fb_big[0] = 3'b011;
    fb_big[5] = 3'b101;
    fb_big[6] = 3'b010;

    // sel: 0 mem_addr, 1 mem_rd, 2 {R,G,B}, 3 BLANK, 4 HS (full-size instance, ascending n)
    add(2,    0, 32'd0,       "addr_0_0");
    add(2,    1, 32'd1,       "rd_0_0");
    add(3,    3, 32'd0,       "blank_before_first");
    add(4,    3, 32'd1,       "blank_first");
    add(4,    2, 32'h00ffff,  "rgb_0_0");
    add(6,    0, 32'd1,       "addr_2_0");
    add(24,   2, 32'hff00ff,  "rgb_10_0");
    add(24,   3, 32'd1,       "blank_10_0");
    add(26,   2, 32'hff00ff,  "rgb_11_0");
    add(28,   2, 32'h00ff00,  "rgb_12_0");
    add(1280, 0, 32'd319,     "addr_639_0");
    add(1282, 1, 32'd0,       "rd_640_0");
    add(1282, 0, 32'd319,     "addr_hold_640_0");
    add(1284, 3, 32'd0,       "blank_640_0");
    add(1284, 2, 32'h000000,  "rgb_640_0");
    add(1314, 4, 32'd1,       "hs_655");
    add(1316, 4, 32'd0,       "hs_656");
    add(1506, 4, 32'd0,       "hs_751");
    add(1508, 4, 32'd1,       "hs_752");
    add(1604, 1, 32'd1,       "rd_1_1");
    add(1604, 0, 32'd0,       "addr_1_1");
    add(1624, 2, 32'hff00ff,  "rgb_10_1");
    add(1628, 2, 32'h00ff00,  "rgb_12_1");
    add(3202, 0, 32'd320,     "addr_0_2");

    repeat (3) step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_to(tbl[i].n, tbl[i].name);
      case (tbl[i].sel)
        0:       act = 32'(b_addr);
        1:       act = 32'(b_rd);
        2:       act = 32'({b_r, b_g, b_b});
        3:       act = 32'(b_blank);
        default: act = 32'(b_hs);
      endcase
      chk(tbl[i].name, 0, act, tbl[i].exp);
    end

    repeat (16000) step();

    // reset at a random mid-frame point, then watch the restart
    rs = $urandom_range(2600, 2000);
    repeat (rs) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (1800) step();

`ifdef VGA_SCANOUT_TESTPATTERN_EN
    rst = 1'b1;
    tm  = 1'b1;
    step();
    rst = 1'b0;
    run_to(4, "tp_start");
    chk("tp_rgb_h0", 0, 32'({b_r, b_g, b_b}), 32'h000000);
    run_to(174, "tp_h85");
    chk("tp_rgb_h85", 0, 32'({b_r, b_g, b_b}), 32'h0000ff);
    run_to(1204, "tp_h600");
    chk("tp_rgb_h600", 0, 32'({b_r, b_g, b_b}), 32'hffffff);
    repeat (600) step();
    rst = 1'b1;
    tm  = 1'b0;
    step();
    rst = 1'b0;
    repeat (200) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
